// File: rtl/lane_arbiter_rr_if.sv
// Handshake bundle for the four-lane round-robin arbiter: lane payload/valid/ready
// plus the merged, registered output word.
interface lane_arbiter_rr_if;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned GRANT_W = 2;

    logic [DATA_W-1:0]  data_0;
    logic [DATA_W-1:0]  data_1;
    logic [DATA_W-1:0]  data_2;
    logic [DATA_W-1:0]  data_3;
    logic               valid_0;
    logic               valid_1;
    logic               valid_2;
    logic               valid_3;
    logic               ready_0;
    logic               ready_1;
    logic               ready_2;
    logic               ready_3;
    logic               out_ready;
    logic [DATA_W-1:0]  data_out;
    logic               valid_out;
    logic [GRANT_W-1:0] grant;

    // Producer/consumer side: drives lanes and out_ready, observes the arbiter.
    modport master (
        output data_0, data_1, data_2, data_3,
        output valid_0, valid_1, valid_2, valid_3,
        output out_ready,
        input  ready_0, ready_1, ready_2, ready_3,
        input  data_out, valid_out, grant
    );

    // Arbiter side.
    modport slave (
        input  data_0, data_1, data_2, data_3,
        input  valid_0, valid_1, valid_2, valid_3,
        input  out_ready,
        output ready_0, ready_1, ready_2, ready_3,
        output data_out, valid_out, grant
    );
endinterface

// File: rtl/lane_arbiter_rr.sv
// Four-lane round-robin arbiter merging lane words into one registered output slot,
// gated by a RESET -> INIT -> IDLE <-> ACTIVE control FSM.
module lane_arbiter_rr #(
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic              clk_f,
    input  logic              reset,
    lane_arbiter_rr_if.slave  bus,
    output logic              idle_out,
    output logic [1:0]        state
);
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    init_cnt_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                valid_out_q;
    logic [PTR_W-1:0]    grant_q;
    logic                idle_q;

    logic [LANES-1:0]    valid_vec;
    logic                any_valid;
    logic [PTR_W-1:0]    winner;
    logic [DATA_W-1:0]   winner_data;
    logic                out_free;
    logic                xfer;
    logic [LANES-1:0]    ready_vec;

    assign valid_vec = {bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0};
    assign any_valid = |valid_vec;

    // Output slot can take a word when empty or being drained this edge.
    assign out_free  = !valid_out_q || bus.out_ready;

    // First valid lane at or after the round-robin pointer.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        winner = ptr_q;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            idx = ptr_q + PTR_W'(k);
            if (!found && valid_vec[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        winner_data = bus.data_0;
        case (winner)
            2'd0:    winner_data = bus.data_0;
            2'd1:    winner_data = bus.data_1;
            2'd2:    winner_data = bus.data_2;
            default: winner_data = bus.data_3;
        endcase
    end

    // Reset term forces ready low combinationally, independent of the state register.
    assign xfer      = !reset && (state_q == ST_ACTIVE) && any_valid && out_free;
    assign ready_vec = xfer ? (LANES'(1) << winner) : '0;

    assign bus.ready_0 = ready_vec[0];
    assign bus.ready_1 = ready_vec[1];
    assign bus.ready_2 = ready_vec[2];
    assign bus.ready_3 = ready_vec[3];

    // Control FSM with registered idle flag and INIT dwell counter.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            init_cnt_q <= '0;
            idle_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_q    <= ST_INIT;
                    init_cnt_q <= '0;
                    idle_q     <= 1'b0;
                end
                ST_INIT: begin
                    if (init_cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                        state_q    <= ST_IDLE;
                        init_cnt_q <= '0;
                        idle_q     <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (any_valid) begin
                        state_q <= ST_ACTIVE;
                        idle_q  <= 1'b0;
                    end
                end
                default: begin
                    if (!any_valid && out_free) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Output slot and round-robin pointer; pointer only advances on a transfer.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            grant_q     <= '0;
        end else if (xfer) begin
            ptr_q       <= winner + PTR_W'(1);
            data_out_q  <= winner_data;
            valid_out_q <= 1'b1;
            grant_q     <= winner;
        end else if (bus.out_ready) begin
            valid_out_q <= 1'b0;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.grant     = grant_q;
    assign idle_out      = idle_q;
    assign state         = state_q;

    a_ready_onehot0: assert property (@(posedge clk_f) disable iff (reset) $onehot0(ready_vec));

endmodule

// File: tb/tb_lane_arbiter_rr.sv
// Directed and randomized scoreboard checks for lane_arbiter_rr.
module tb_lane_arbiter_rr;
    logic       clk_f;
    logic       reset;
    logic       idle_out;
    logic [1:0] state;
    logic [3:0] tb_valid;
    logic [7:0] tb_data [4];
    logic       tb_out_ready;
    wire  [3:0] rdy;

    int n_pass;
    int n_total;

    lane_arbiter_rr_if bus ();

    assign bus.data_0    = tb_data[0];
    assign bus.data_1    = tb_data[1];
    assign bus.data_2    = tb_data[2];
    assign bus.data_3    = tb_data[3];
    assign bus.valid_0   = tb_valid[0];
    assign bus.valid_1   = tb_valid[1];
    assign bus.valid_2   = tb_valid[2];
    assign bus.valid_3   = tb_valid[3];
    assign bus.out_ready = tb_out_ready;
    assign rdy = {bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0};

    lane_arbiter_rr #(.INIT_CYCLES(4)) dut (
        .clk_f    (clk_f),
        .reset    (reset),
        .bus      (bus),
        .idle_out (idle_out),
        .state    (state)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    task automatic step();
        @(posedge clk_f);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tb_valid = 4'b0001;
        tb_out_ready = 1'b1;
        step();
        step();
        n_total++; if (state !== 2'b00) $display("FAIL rst_state got=%b exp=00", state); else n_pass++;
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL rst_valid_out got=%b exp=0", bus.valid_out); else n_pass++;
        n_total++; if (bus.data_out !== 8'h00) $display("FAIL rst_data_out got=%h exp=00", bus.data_out); else n_pass++;
        n_total++; if (bus.grant !== 2'd0) $display("FAIL rst_grant got=%0d exp=0", bus.grant); else n_pass++;
        n_total++; if (idle_out !== 1'b0) $display("FAIL rst_idle got=%b exp=0", idle_out); else n_pass++;
        n_total++; if (rdy !== 4'b0000) $display("FAIL rst_ready got=%b exp=0000", rdy); else n_pass++;
        tb_valid = 4'b0000;
        reset = 1'b0;
        #1;
        n_total++; if (state !== 2'b00) $display("FAIL rel_state got=%b exp=00", state); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++; if (state !== 2'b01) $display("FAIL init_state[%0d] got=%b exp=01", i, state); else n_pass++;
        end
        step();
        n_total++; if (state !== 2'b10) $display("FAIL idle_state got=%b exp=10", state); else n_pass++;
        n_total++; if (idle_out !== 1'b1) $display("FAIL idle_out got=%b exp=1", idle_out); else n_pass++;
    endtask

    task automatic test_all_lanes();
        logic [7:0] exp_d [4];
        logic [3:0] exp_r;
        exp_d[0] = 8'hFF; exp_d[1] = 8'hEE; exp_d[2] = 8'hDD; exp_d[3] = 8'hCC;
        for (int i = 0; i < 4; i++) tb_data[i] = exp_d[i];
        tb_valid = 4'b1111;
        tb_out_ready = 1'b1;
        #1;
        n_total++; if (rdy !== 4'b0000) $display("FAIL all_idle_ready got=%b exp=0000", rdy); else n_pass++;
        step();
        n_total++; if (state !== 2'b11) $display("FAIL all_active got=%b exp=11", state); else n_pass++;
        n_total++; if (idle_out !== 1'b0) $display("FAIL all_idle_out got=%b exp=0", idle_out); else n_pass++;
        n_total++; if (rdy !== 4'b0001) $display("FAIL all_ready0 got=%b exp=0001", rdy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_r = 4'b0001 << ((i + 1) % 4);
            n_total++; if (bus.data_out !== exp_d[i]) $display("FAIL all_data[%0d] got=%h exp=%h", i, bus.data_out, exp_d[i]); else n_pass++;
            n_total++; if (bus.grant !== 2'(i)) $display("FAIL all_grant[%0d] got=%0d exp=%0d", i, bus.grant, i); else n_pass++;
            n_total++; if (bus.valid_out !== 1'b1) $display("FAIL all_vout[%0d] got=%b exp=1", i, bus.valid_out); else n_pass++;
            n_total++; if (rdy !== exp_r) $display("FAIL all_ready[%0d] got=%b exp=%b", i, rdy, exp_r); else n_pass++;
        end
        tb_valid = 4'b0000;
        step();
        n_total++; if (state !== 2'b10) $display("FAIL all_back_idle got=%b exp=10", state); else n_pass++;
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL all_drain got=%b exp=0", bus.valid_out); else n_pass++;
        n_total++; if (bus.data_out !== 8'hCC) $display("FAIL all_hold_data got=%h exp=cc", bus.data_out); else n_pass++;
        n_total++; if (bus.grant !== 2'd3) $display("FAIL all_hold_grant got=%0d exp=3", bus.grant); else n_pass++;
    endtask

    task automatic test_single_lane();
        tb_data[2] = 8'h77;
        tb_valid = 4'b0100;
        tb_out_ready = 1'b1;
        step();
        n_total++; if (rdy !== 4'b0100) $display("FAIL one_ready got=%b exp=0100", rdy); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) tb_valid = 4'b0000;
            #1;
            n_total++; if (bus.data_out !== 8'h77) $display("FAIL one_data[%0d] got=%h exp=77", i, bus.data_out); else n_pass++;
            n_total++; if (bus.grant !== 2'd2) $display("FAIL one_grant[%0d] got=%0d exp=2", i, bus.grant); else n_pass++;
            n_total++; if (bus.valid_out !== 1'b1) $display("FAIL one_vout[%0d] got=%b exp=1", i, bus.valid_out); else n_pass++;
            n_total++; if (rdy !== ((i == 2) ? 4'b0000 : 4'b0100)) $display("FAIL one_ready[%0d] got=%b", i, rdy); else n_pass++;
        end
        step();
        n_total++; if (state !== 2'b10) $display("FAIL one_back_idle got=%b exp=10", state); else n_pass++;
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL one_drain got=%b exp=0", bus.valid_out); else n_pass++;
    endtask

    // Pointer is 3 here: lane 3 wins first, then a 5-cycle stall, then lanes 0, 1.
    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) tb_data[i] = 8'h10 + 8'(i);
        tb_valid = 4'b1111;
        tb_out_ready = 1'b1;
        step();
        n_total++; if (rdy !== 4'b1000) $display("FAIL bp_first_ready got=%b exp=1000", rdy); else n_pass++;
        step();
        n_total++; if (bus.data_out !== 8'h13) $display("FAIL bp_first_data got=%h exp=13", bus.data_out); else n_pass++;
        tb_out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (rdy !== 4'b0000) $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", i, rdy); else n_pass++;
            step();
            n_total++; if (bus.data_out !== 8'h13) $display("FAIL bp_stall_data[%0d] got=%h exp=13", i, bus.data_out); else n_pass++;
            n_total++; if (bus.grant !== 2'd3) $display("FAIL bp_stall_grant[%0d] got=%0d exp=3", i, bus.grant); else n_pass++;
            n_total++; if (bus.valid_out !== 1'b1) $display("FAIL bp_stall_vout[%0d] got=%b exp=1", i, bus.valid_out); else n_pass++;
        end
        tb_out_ready = 1'b1;
        #1;
        n_total++; if (rdy !== 4'b0001) $display("FAIL bp_resume_ready got=%b exp=0001", rdy); else n_pass++;
        step();
        n_total++; if (bus.data_out !== 8'h10) $display("FAIL bp_resume_data got=%h exp=10", bus.data_out); else n_pass++;
        n_total++; if (bus.grant !== 2'd0) $display("FAIL bp_resume_grant got=%0d exp=0", bus.grant); else n_pass++;
        n_total++; if (rdy !== 4'b0010) $display("FAIL bp_next_ready got=%b exp=0010", rdy); else n_pass++;
        step();
        n_total++; if (bus.grant !== 2'd1) $display("FAIL bp_next_grant got=%0d exp=1", bus.grant); else n_pass++;
        tb_valid = 4'b0000;
        step();
        n_total++; if (state !== 2'b10) $display("FAIL bp_back_idle got=%b exp=10", state); else n_pass++;
    endtask

    // Pointer is 2 here: one transfer of lane 2, then reset asserted between edges.
    task automatic test_reset_mid();
        tb_data[0] = 8'hFF; tb_data[1] = 8'hEE; tb_data[2] = 8'hDD; tb_data[3] = 8'hCC;
        tb_valid = 4'b1111;
        tb_out_ready = 1'b0;
        step();
        step();
        n_total++; if (bus.data_out !== 8'hDD) $display("FAIL rm_pre_data got=%h exp=dd", bus.data_out); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL rm_vout got=%b exp=0", bus.valid_out); else n_pass++;
        n_total++; if (bus.data_out !== 8'h00) $display("FAIL rm_data got=%h exp=00", bus.data_out); else n_pass++;
        n_total++; if (state !== 2'b00) $display("FAIL rm_state got=%b exp=00", state); else n_pass++;
        n_total++; if (rdy !== 4'b0000) $display("FAIL rm_ready got=%b exp=0000", rdy); else n_pass++;
        tb_valid = 4'b0000;
        tb_out_ready = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_total++; if (state !== 2'b00) $display("FAIL rm_rel_state got=%b exp=00", state); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++; if (state !== 2'b01) $display("FAIL rm_init[%0d] got=%b exp=01", i, state); else n_pass++;
        end
        step();
        n_total++; if (state !== 2'b10) $display("FAIL rm_idle got=%b exp=10", state); else n_pass++;
        n_total++; if (idle_out !== 1'b1) $display("FAIL rm_idle_out got=%b exp=1", idle_out); else n_pass++;
    endtask

    // Random lanes and out_ready against a behavioural model and a word scoreboard.
    task automatic test_random();
        logic [9:0]  sb [$];
        logic [9:0]  got;
        logic [1:0]  m_ptr;
        logic [1:0]  w;
        logic [1:0]  idx;
        logic [3:0]  acc;
        logic [3:0]  exp_r;
        logic [7:0]  word_id;
        bit          m_active;
        bit          m_vout;
        bit          found;
        bit          free;
        m_ptr = 2'd0; m_active = 1'b0; m_vout = 1'b0; acc = 4'b0; word_id = 8'h40;
        for (int cyc = 0; cyc < 206; cyc++) begin
            if (cyc < 200) begin
                for (int i = 0; i < 4; i++) begin
                    if (!tb_valid[i] || acc[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            tb_valid[i] = 1'b1;
                            tb_data[i] = word_id;
                            word_id = word_id + 8'd1;
                        end else begin
                            tb_valid[i] = 1'b0;
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        tb_valid[i] = 1'b0;
                    end
                end
                tb_out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                tb_valid = 4'b0000;
                tb_out_ready = 1'b1;
            end
            #1;
            free = !m_vout || tb_out_ready;
            found = 1'b0;
            w = m_ptr;
            for (int k = 0; k < 4; k++) begin
                idx = m_ptr + 2'(k);
                if (!found && tb_valid[idx]) begin
                    w = idx;
                    found = 1'b1;
                end
            end
            exp_r = (m_active && found && free) ? (4'b0001 << w) : 4'b0000;
            n_total++; if (rdy !== exp_r) $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, rdy, exp_r); else n_pass++;
            if (bus.valid_out && tb_out_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL rnd_extra_word[%0d] got=%h exp=none", cyc, {bus.grant, bus.data_out});
                end else begin
                    got = sb.pop_front();
                    if ({bus.grant, bus.data_out} !== got) $display("FAIL rnd_word[%0d] got=%h exp=%h", cyc, {bus.grant, bus.data_out}, got);
                    else n_pass++;
                end
            end
            acc = exp_r;
            if (|exp_r) sb.push_back({w, tb_data[w]});
            step();
            if (|exp_r) begin
                m_vout = 1'b1;
                m_ptr = w + 2'd1;
            end else if (tb_out_ready) begin
                m_vout = 1'b0;
            end
            if (!m_active && (|tb_valid)) m_active = 1'b1;
            else if (m_active && !(|tb_valid) && free) m_active = 1'b0;
            n_total++; if (bus.valid_out !== m_vout) $display("FAIL rnd_vout[%0d] got=%b exp=%b", cyc, bus.valid_out, m_vout); else n_pass++;
            n_total++; if (state !== (m_active ? 2'b11 : 2'b10)) $display("FAIL rnd_state[%0d] got=%b exp=%b", cyc, state, m_active ? 2'b11 : 2'b10); else n_pass++;
        end
        n_total++; if (sb.size() != 0) $display("FAIL rnd_lost_words got=%0d exp=0", sb.size()); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        tb_valid = 4'b0000;
        tb_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tb_data[i] = 8'h00;
        test_reset();
        test_all_lanes();
        test_single_lane();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/lane_arbiter_rr.md
LANE_ARBITER_RR -- requirements
Module: lane_arbiter_rr

Interface
REQ-001 Parameter INIT_CYCLES, default 4: number of clk_f cycles spent in INIT after reset release; legal range 1..15.
REQ-002 clk_f  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_0, data_1, data_2, data_3  input  8 each  lane payloads.
REQ-005 valid_0, valid_1, valid_2, valid_3  input  1 each  lane request, held until accepted.
REQ-006 ready_0, ready_1, ready_2, ready_3  output  1 each  lane accept; combinational.
REQ-007 out_ready  input  1  downstream accept of data_out.
REQ-008 data_out  output  8  registered merged payload.
REQ-009 valid_out  output  1  registered; data_out holds a word.
REQ-010 grant  output  2  registered; lane index of the word in data_out.
REQ-011 idle_out  output  1  registered; high only in IDLE.
REQ-012 state  output  2  FSM state: RESET=00, INIT=01, IDLE=10, ACTIVE=11.

Function
REQ-013 FSM transitions: RESET->INIT on the first edge after reset release; INIT->IDLE after exactly INIT_CYCLES cycles in INIT; IDLE->ACTIVE when any valid_i is high; ACTIVE->IDLE when all valid_i are low and the output register is empty or draining (valid_out=0, or out_ready=1).
REQ-014 A lane transfer occurs on an edge where valid_i and ready_i are both high.
REQ-015 ready_i = state==ACTIVE AND lane i is the arbitration winner AND (valid_out==0 OR out_ready==1).
REQ-016 At most one ready_i is high in any cycle.
REQ-017 Winner: first lane with valid high, searching ptr, ptr+1, ptr+2, ptr+3 mod 4; ptr is a 2-bit round-robin pointer.
REQ-018 ptr updates to (winner+1) mod 4 only on a transfer; it is unchanged when no transfer occurs.
REQ-019 Latency: a transfer at edge N makes data_out=data_i, grant=i, valid_out=1 visible after edge N (one cycle).
REQ-020 Without a new transfer, valid_out clears on an edge where out_ready=1, and data_out/grant keep their last values.
REQ-021 With out_ready=0 and valid_out=1, data_out, grant and valid_out hold stable and all ready_i stay low.
REQ-022 In RESET, INIT and IDLE, all ready_i stay low and valid inputs are ignored; the first transfer therefore occurs in the first ACTIVE cycle.
REQ-023 All four lanes continuously valid with out_ready=1: grant sequence 0,1,2,3,0,... with one word per cycle.
REQ-024 A single continuously valid lane is granted every cycle.
REQ-025 Lane valid drop without acceptance: no transfer and no ptr change.
REQ-026 idle_out=1 iff state==IDLE, registered with the state.

Reset
REQ-027 On reset assertion, asynchronously: state=RESET, ptr=0, INIT counter=0, data_out=8'h00, valid_out=0, grant=0, idle_out=0.
REQ-028 ready_i goes low combinationally while reset is high.
REQ-029 Reset asserted mid-transfer discards any held output word, and the block restarts from RESET on release.

Verification
REQ-030 Reset release with INIT_CYCLES=4 and no valids -> state 00, then 01 for 4 cycles, then 10 with idle_out=1.
REQ-031 In IDLE with data 0xFF/0xEE/0xDD/0xCC, all valid, out_ready=1 -> data_out 0xFF, 0xEE, 0xDD, 0xCC, with grant 0,1,2,3, one per cycle.
REQ-032 Only valid_2 high with 0x77 for 3 cycles -> data_out=0x77 and grant=2 for 3 consecutive cycles, then the FSM returns to IDLE.
REQ-033 out_ready low for 5 cycles with valid_out=1 -> data_out stable, all ready_i low, no ptr change; resume continues rotation from the correct lane.
REQ-034 Reset pulsed during ACTIVE traffic -> valid_out=0 and data_out=0x00 immediately, without waiting for a clock edge; INIT sequence repeats.
REQ-035 Random valids and out_ready for 200 cycles -> scoreboard shows no lost or duplicated words, at most one ready_i per cycle, and round-robin order respected.
